// File: rtl/soc_top_arcdvi.sv
`default_nettype none
// ============================================================================
//  Module   : soc_top_arcdvi
//  Brief    : ArcDVI top. Snoops VIDC register writes into a 64-entry shadow
//             and exposes shadow, ID/status and video control over 48-bit SPI.
//  Revision : 1.0 - initial release
// ============================================================================
module soc_top_arcdvi #(
    parameter logic [31:0] ID_VALUE = 32'hA7CD_0100
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        spi_clk,
    input  logic        spi_ncs,
    input  logic        spi_din,
    output logic        spi_dout,
    input  logic [31:0] vidc_d,
    input  logic        vidc_nvidw,
    input  logic        vidc_nvcs,
    input  logic        vidc_nhs,
    input  logic        vidc_nsndrq,
    input  logic        vidc_nvidrq,
    input  logic        vidc_nsndak,
    input  logic        vidc_nvidak,
    input  logic        vidc_flybk,
    input  logic        vidc_ckin,
    output logic        video_sync_req,
    output logic        pclk_reset
);

    localparam logic [11:0] c_ADDR_ID     = 12'h800;
    localparam logic [11:0] c_ADDR_FRAMES = 12'h801;
    localparam logic [11:0] c_ADDR_STATUS = 12'h802;
    localparam logic [11:0] c_ADDR_VSYNC  = 12'h808;
    localparam logic [11:0] c_ADDR_PCLK   = 12'hC01;
    localparam logic [5:0]  c_BIT_RDATA   = 6'd14;
    localparam logic [5:0]  c_BIT_TXLOAD  = 6'd16;
    localparam logic [5:0]  c_BIT_LAST    = 6'd47;
    localparam logic [5:0]  c_BIT_FULL    = 6'd48;
    // {flybk, nvidrq, nvidak, nhs, nvcs, nvidw, din, ncs, sclk}; idle levels avoid false edges
    localparam logic [8:0]  c_SYNC_RST    = 9'b0_1_1_1_1_1_0_1_0;

    logic [8:0]  w_async_in;
    logic [8:0]  r_sync1;
    logic [8:0]  r_sync2;
    logic [8:0]  r_sync3;
    logic [31:0] r_vidc_d;
    logic [31:0] r_hold;
    logic [23:0] r_shadow [64];
    logic [15:0] r_frame_cnt;
    logic [5:0]  r_bit_cnt;
    logic [47:0] r_rx;
    logic [31:0] r_tx;
    logic [31:0] r_rdata;
    logic        r_wr_pend;
    logic [31:0] w_rdata;
    logic [4:0]  w_status;
    logic [11:0] w_wr_addr;
    logic [31:0] w_wr_data;
    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_ncs;
    logic        w_ncs_fall;
    logic        w_nvidw_rise;
    logic        w_nvcs_fall;
    logic        w_unused;

    assign w_async_in = {vidc_flybk, vidc_nvidrq, vidc_nvidak, vidc_nhs, vidc_nvcs,
                         vidc_nvidw, spi_din, spi_ncs, spi_clk};

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= c_SYNC_RST;
            r_sync2  <= c_SYNC_RST;
            r_sync3  <= c_SYNC_RST;
            r_vidc_d <= '0;
        end else begin
            r_sync1  <= w_async_in;
            r_sync2  <= r_sync1;
            r_sync3  <= r_sync2;
            r_vidc_d <= vidc_d;
        end
    end

    assign w_sclk_rise  =  r_sync2[0] & ~r_sync3[0];
    assign w_sclk_fall  = ~r_sync2[0] &  r_sync3[0];
    assign w_ncs        =  r_sync2[1];
    assign w_ncs_fall   = ~r_sync2[1] &  r_sync3[1];
    assign w_nvidw_rise =  r_sync2[3] & ~r_sync3[3];
    assign w_nvcs_fall  = ~r_sync2[4] &  r_sync3[4];
    assign w_status     = {r_sync2[8], r_sync2[7], r_sync2[6], r_sync2[4], r_sync2[5]};
    assign w_wr_addr    = r_rx[45:34];
    assign w_wr_data    = r_rx[31:0];

    // Capture only while both sync stages are low, so r_vidc_d is known to be
    // from inside the strobe and DMA data arriving right after it is never taken.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_hold      <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (!r_sync1[3] && !r_sync2[3]) begin
                r_hold <= r_vidc_d;
            end
            if (w_nvcs_fall) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    for (genvar gi = 0; gi < 64; gi++) begin : g_shadow
        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                r_shadow[gi] <= '0;
            end else if (w_nvidw_rise && (r_hold[31:26] == 6'(gi))) begin
                r_shadow[gi] <= r_hold[23:0];
            end else if (r_wr_pend && (w_wr_addr == 12'(gi))) begin
                r_shadow[gi] <= w_wr_data[23:0];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (!r_rx[13]) begin
            if (r_rx[11:6] == 6'd0) begin
                w_rdata = {8'h00, r_shadow[r_rx[5:0]]};
            end else begin
                case (r_rx[11:0])
                    c_ADDR_ID:     w_rdata = ID_VALUE;
                    c_ADDR_FRAMES: w_rdata = {16'h0000, r_frame_cnt};
                    c_ADDR_STATUS: w_rdata = {27'd0, w_status};
                    c_ADDR_VSYNC:  w_rdata = {31'd0, video_sync_req};
                    c_ADDR_PCLK:   w_rdata = {31'd0, pclk_reset};
                    default:       w_rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= '0;
            r_rx      <= '0;
            r_tx      <= '0;
            r_rdata   <= '0;
            r_wr_pend <= 1'b0;
            spi_dout  <= 1'b0;
        end else begin
            r_wr_pend <= 1'b0;
            if (w_ncs) begin
                spi_dout <= 1'b0;
            end else if (w_ncs_fall) begin
                r_bit_cnt <= '0;
                spi_dout  <= 1'b0;
            end else begin
                if (w_sclk_rise && (r_bit_cnt != c_BIT_FULL)) begin
                    r_rx      <= {r_rx[46:0], r_sync2[2]};
                    r_bit_cnt <= r_bit_cnt + 6'd1;
                    if ((r_bit_cnt == c_BIT_LAST) && (r_rx[46:45] == 2'b01)) begin
                        r_wr_pend <= 1'b1;
                    end
                end
                if (r_bit_cnt == c_BIT_RDATA) begin
                    r_rdata <= w_rdata;
                end
                if (w_sclk_fall) begin
                    if (r_bit_cnt == c_BIT_TXLOAD) begin
                        spi_dout <= r_rdata[31];
                        r_tx     <= {r_rdata[30:0], 1'b0};
                    end else if (r_bit_cnt > c_BIT_TXLOAD) begin
                        spi_dout <= r_tx[31];
                        r_tx     <= {r_tx[30:0], 1'b0};
                    end else begin
                        spi_dout <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            video_sync_req <= 1'b0;
            pclk_reset     <= 1'b0;
        end else if (r_wr_pend) begin
            if (w_wr_addr == c_ADDR_VSYNC) begin
                video_sync_req <= w_wr_data[0];
            end
            if (w_wr_addr == c_ADDR_PCLK) begin
                pclk_reset <= w_wr_data[0];
            end
        end
    end

    assign w_unused = ^{vidc_nsndrq, vidc_nsndak, vidc_ckin, r_hold[25:24], r_rx[47],
                        r_rx[33:24], r_sync3[8:5], r_sync3[2]};

endmodule
`default_nettype wire

// File: tb/tb_soc_top_arcdvi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_soc_top_arcdvi
//  Brief    : Scoreboard bench for soc_top_arcdvi with a register-map model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_soc_top_arcdvi;

    localparam int c_HALF = 120;

    logic        clk_in = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_ncs = 1'b1;
    logic        spi_din = 1'b0;
    logic        spi_dout;
    logic [31:0] vidc_d = '0;
    logic        vidc_nvidw = 1'b1;
    logic        vidc_nvcs = 1'b1;
    logic        vidc_nhs = 1'b1;
    logic        vidc_nsndrq = 1'b1;
    logic        vidc_nvidrq = 1'b1;
    logic        vidc_nsndak = 1'b1;
    logic        vidc_nvidak = 1'b1;
    logic        vidc_flybk = 1'b0;
    logic        vidc_ckin = 1'b0;
    logic        video_sync_req;
    logic        pclk_reset;

    soc_top_arcdvi dut (
        .clk_in(clk_in), .reset_n(reset_n),
        .spi_clk(spi_clk), .spi_ncs(spi_ncs), .spi_din(spi_din), .spi_dout(spi_dout),
        .vidc_d(vidc_d), .vidc_nvidw(vidc_nvidw), .vidc_nvcs(vidc_nvcs), .vidc_nhs(vidc_nhs),
        .vidc_nsndrq(vidc_nsndrq), .vidc_nvidrq(vidc_nvidrq), .vidc_nsndak(vidc_nsndak),
        .vidc_nvidak(vidc_nvidak), .vidc_flybk(vidc_flybk), .vidc_ckin(vidc_ckin),
        .video_sync_req(video_sync_req), .pclk_reset(pclk_reset)
    );

    initial forever #10 clk_in = ~clk_in;

    // Reference model of the register map
    logic [23:0] m_shadow [64];
    logic [15:0] m_frames = '0;
    logic        m_vsync = 1'b0;
    logic        m_pclk = 1'b0;

    logic [47:0] q_rd_exp [$];
    logic [11:0] q_rd_addr [$];
    logic [2:0]  q_ct_exp [$];
    string       q_ct_name [$];
    int          checks = 0;
    int          errors = 0;
    logic [47:0] last_rx;
    logic [47:0] mon_e;
    logic [11:0] mon_a;
    logic [2:0]  mon_c;
    string       mon_n;
    event        ev_frame;
    event        ev_ctrl;

    function automatic logic [31:0] m_read(input logic [1:0] cmd, input logic [11:0] addr);
        if (cmd[1]) return 32'h0;
        if (addr < 12'd64) return {8'h00, m_shadow[addr[5:0]]};
        case (addr)
            12'h800: return 32'hA7CD_0100;
            12'h801: return {16'h0, m_frames};
            12'h802: return {27'h0, vidc_flybk, vidc_nvidrq, vidc_nvidak, vidc_nvcs, vidc_nhs};
            12'h808: return {31'h0, m_vsync};
            12'hC01: return {31'h0, m_pclk};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void m_write(input logic [11:0] addr, input logic [31:0] data);
        if (addr < 12'd64) m_shadow[addr[5:0]] = data[23:0];
        else if (addr == 12'h808) m_vsync = data[0];
        else if (addr == 12'hC01) m_pclk = data[0];
    endfunction

    // Monitor: compare every completed read frame against the scoreboard
    initial forever begin
        @(ev_frame);
        checks++;
        if (q_rd_exp.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame got=%012h want=none", last_rx);
        end else begin
            mon_e = q_rd_exp.pop_front();
            mon_a = q_rd_addr.pop_front();
            if (last_rx !== mon_e) begin
                errors++;
                $display("FAIL read_%03h got=%012h want=%012h", mon_a, last_rx, mon_e);
            end
        end
    end

    // Monitor: compare control outputs {spi_dout, pclk_reset, video_sync_req}
    initial forever begin
        @(ev_ctrl);
        checks++;
        if (q_ct_exp.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ctrl got=%b want=none", {spi_dout, pclk_reset, video_sync_req});
        end else begin
            mon_c = q_ct_exp.pop_front();
            mon_n = q_ct_name.pop_front();
            if ({spi_dout, pclk_reset, video_sync_req} !== mon_c) begin
                errors++;
                $display("FAIL ctrl_%s got=%b want=%b", mon_n,
                         {spi_dout, pclk_reset, video_sync_req}, mon_c);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout want=finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks + 1);
        $fatal(1);
    end

    task automatic spi_frame(input logic [1:0] cmd, input logic [11:0] addr,
                             input logic [31:0] data, input int nbits);
        logic [47:0] f;
        logic [47:0] r;
        f = {cmd, addr, 2'b00, data};
        r = '0;
        @(negedge clk_in);
        spi_ncs = 1'b0;
        #(c_HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_din = f[47-i];
            #(c_HALF);
            r[47-i] = spi_dout;
            spi_clk = 1'b1;
            #(c_HALF);
            spi_clk = 1'b0;
        end
        #(c_HALF);
        spi_ncs = 1'b1;
        spi_din = 1'b0;
        #(4*c_HALF);
        last_rx = r;
    endtask

    task automatic spi_read(input logic [1:0] cmd, input logic [11:0] addr);
        q_rd_exp.push_back({16'h0, m_read(cmd, addr)});
        q_rd_addr.push_back(addr);
        spi_frame(cmd, addr, $urandom, 48);
        -> ev_frame;
    endtask

    task automatic spi_write(input logic [11:0] addr, input logic [31:0] data);
        spi_frame(2'b01, addr, data, 48);
        m_write(addr, data);
    endtask

    task automatic ctrl_check(input string name);
        @(negedge clk_in);
        q_ct_exp.push_back({1'b0, m_pclk, m_vsync});
        q_ct_name.push_back(name);
        -> ev_ctrl;
    endtask

    task automatic vidc_write(input logic [5:0] idx, input logic [23:0] data, input int lowcyc);
        logic [1:0] junk;
        junk = 2'($urandom);
        @(negedge clk_in);
        vidc_d = {idx, junk, data};
        vidc_nvidw = 1'b0;
        repeat (lowcyc) @(negedge clk_in);
        vidc_nvidw = 1'b1;
        @(negedge clk_in);
        vidc_d = $urandom;
        repeat (4) @(negedge clk_in);
        m_shadow[idx] = data;
    endtask

    task automatic video_frames(input int nframes);
        for (int f = 0; f < nframes; f++) begin
            @(negedge clk_in);
            vidc_nvcs = 1'b0;
            repeat (3) @(negedge clk_in);
            vidc_nvcs = 1'b1;
            m_frames = m_frames + 16'd1;
            for (int l = 0; l < 4; l++) begin
                vidc_nhs = 1'b0;
                repeat (2) @(negedge clk_in);
                vidc_nhs = 1'b1;
                for (int k = 0; k < 8; k++) begin
                    vidc_d = vidc_d + 32'h0102_0304;
                    @(negedge clk_in);
                end
            end
        end
        repeat (4) @(negedge clk_in);
    endtask

    initial begin
        logic [11:0] a;
        logic [31:0] d;
        int          op;
        for (int i = 0; i < 64; i++) m_shadow[i] = '0;

        repeat (4) @(negedge clk_in);
        ctrl_check("in_reset");
        reset_n = 1'b1;
        repeat (4) @(negedge clk_in);
        ctrl_check("after_reset");

        spi_read(2'b00, 12'h800);
        spi_read(2'b00, 12'h123);
        spi_read(2'b00, 12'h02A);

        for (int v = 0; v < 16; v++) begin
            vidc_write(6'(v), {12'h000, 4'(v), 4'(v), 4'(v)}, 2 + (v % 3));
        end
        vidc_write(6'h14, 24'h5a5a5a, 2);
        vidc_write(6'h15, 24'hcace00, 3);
        spi_read(2'b00, 12'h000);
        spi_read(2'b00, 12'h00F);
        spi_read(2'b00, 12'h014);
        spi_read(2'b00, 12'h015);

        vidc_d = 32'h1400_0000;
        video_frames(3);
        spi_read(2'b00, 12'h801);
        spi_read(2'b00, 12'h014);
        spi_read(2'b00, 12'h007);
        video_frames(2);
        spi_read(2'b00, 12'h801);
        vidc_flybk = 1'b1;
        vidc_nvidak = 1'b0;
        vidc_nhs = 1'b0;
        repeat (4) @(negedge clk_in);
        spi_read(2'b00, 12'h802);
        vidc_nhs = 1'b1;

        spi_write(12'h808, 32'h0000_0001);
        ctrl_check("vsync_set");
        spi_read(2'b00, 12'h808);
        spi_write(12'hC01, 32'h0000_0001);
        ctrl_check("pclk_set");
        spi_write(12'hC01, 32'h0000_0000);
        ctrl_check("pclk_clear");

        spi_frame(2'b01, 12'h808, 32'h0000_0000, 20);
        ctrl_check("abort_keeps_vsync");
        spi_read(2'b00, 12'h015);

        spi_write(12'h005, 32'h00ab_cdef);
        spi_read(2'b00, 12'h005);
        vidc_write(6'h05, 24'h123456, 2);
        spi_read(2'b00, 12'h005);

        for (int n = 0; n < 30; n++) begin
            op = $urandom_range(0, 4);
            case ($urandom_range(0, 5))
                0: a = 12'h808;
                1: a = 12'hC01;
                2: a = 12'(12'h800 + $urandom_range(0, 2));
                3: a = 12'($urandom_range(12'h040, 12'hBFF));
                default: a = 12'($urandom_range(0, 63));
            endcase
            d = $urandom;
            if (op == 0) begin
                vidc_write(6'($urandom_range(0, 63)), 24'($urandom), $urandom_range(2, 4));
            end else if (op == 1) begin
                spi_write(a, d);
                ctrl_check("rand_write");
            end else if (op == 2) begin
                spi_frame(2'($urandom_range(2, 3)), a, d, 48);
                ctrl_check("rand_ignored_cmd");
            end else if (op == 3) begin
                spi_read(2'($urandom_range(2, 3)), a);
            end else begin
                spi_read(2'b00, a);
            end
        end
        for (int i = 0; i < 64; i += 9) spi_read(2'b00, 12'(i));

        repeat (10) @(negedge clk_in);
        checks++;
        if (q_rd_exp.size() != 0 || q_ct_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", q_rd_exp.size() + q_ct_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
